decode_ctrl_stage: RTL



---
 rtl/decode_ctrl_stage.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// Purpose : RV32 decode stage; decodes instr_i into a control bundle held in the ID/EX register,
//           with a load-use hazard detector that inserts LU_STALL bubbles and a flush input.
// Latency : 1 cycle from handshake (in_valid_i & in_ready_o) to out_valid_o.
// Backpr. : while out_valid_o=1 and out_ready_i=0 all outputs hold and in_ready_o=0.
// Ports   : clk_i/rst_i (sync, active-high); in_valid_i/instr_i/in_ready_o upstream handshake;
//           flush_i kills the held bundle; out_ready_i/out_valid_o downstream handshake;
//           branch_o..jump_o, aluop_o, writeback_o control bits; rs1_o/rs2_o/rd_o indices;
//           illegal_o illegal-instruction flag.
// Macro   : DECODE_ILLEGAL_TRAP_EN - illegal encodings become bubbles and set a sticky
//           illegal_o that blocks intake until rst_i/flush_i. Undefined: they decode as I-ALU.
module decode_ctrl_stage #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int LU_STALL   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [INSTR_W-1:0]    instr_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic                  branch_o,
  output logic                  alusrc_o,
  output logic                  regwrite_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic                  jump_o,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [1:0]            writeback_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  illegal_o
);

  typedef struct packed {
    logic               branch;
    logic               alusrc;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         writeback;
  } ctrl_t;

  typedef enum logic {RUN, STALL} state_t;

  // Counter holds the number of bubbles still owed after the one being loaded now.
  localparam logic [1:0] STALL_INIT = 2'(LU_STALL - 1);

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] dec_rd, dec_rs1, dec_rs2;
  logic                  is_r, is_ialu, is_lw, is_sw, is_br, is_jal, is_jalr;
  logic                  dec_illegal, alu_like, use_rs1, use_rs2;
  ctrl_t                 dec_ctrl;
  logic                  unused_funct7;

  assign opcode        = instr_i[6:0];
  assign funct3        = instr_i[14:12];
  assign dec_rd        = instr_i[7 +: REG_ADDR_W];
  assign dec_rs1       = instr_i[15 +: REG_ADDR_W];
  assign dec_rs2       = instr_i[20 +: REG_ADDR_W];
  assign unused_funct7 = ^instr_i[INSTR_W-1:25];

  assign is_r    = (opcode == 7'b0110011);
  assign is_ialu = (opcode == 7'b0010011) && (funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011);
  assign is_br   = (opcode == 7'b1100011);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign dec_illegal = ~(is_r | is_ialu | is_lw | is_sw | is_br | is_jal | is_jalr);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign alu_like = is_ialu;
`else
  // Without the trap, an illegal encoding is treated exactly like an I-ALU op.
  assign alu_like = is_ialu | dec_illegal;
`endif

  assign use_rs1 = is_r | alu_like | is_lw | is_sw | is_br | is_jalr;
  assign use_rs2 = is_r | is_sw | is_br;

  always_comb begin
    dec_ctrl = '0;
    if (is_r) begin
      dec_ctrl.regwrite = 1'b1;
      dec_ctrl.aluop    = ALUOP_W'(2'b10);
    end
    if (alu_like) begin
      dec_ctrl.alusrc   = 1'b1;
      dec_ctrl.regwrite = 1'b1;
      dec_ctrl.aluop    = ALUOP_W'(2'b11);
    end
    if (is_lw) begin
      dec_ctrl.alusrc    = 1'b1;
      dec_ctrl.regwrite  = 1'b1;
      dec_ctrl.memread   = 1'b1;
      dec_ctrl.writeback = 2'b01;
    end
    if (is_sw) begin
      dec_ctrl.alusrc   = 1'b1;
      dec_ctrl.memwrite = 1'b1;
    end
    if (is_br) begin
      dec_ctrl.branch = 1'b1;
      dec_ctrl.aluop  = ALUOP_W'(2'b01);
    end
    if (is_jal || is_jalr) begin
      dec_ctrl.jump      = 1'b1;
      dec_ctrl.regwrite  = 1'b1;
      dec_ctrl.writeback = 2'b10;
      dec_ctrl.alusrc    = is_jalr;
    end
  end

  // ---------------------------------------------------------------------------
  // Held bundle, hazard and handshake
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  out_valid_q;
  ctrl_t                 ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic                  adv, hazard, handshake, trap_block, trap_reject, take_instr;

  assign adv = out_ready_i | ~out_valid_q;

  assign hazard = out_valid_q & ctrl_q.memread & (rd_q != '0) & in_valid_i &
                  ((use_rs1 & (dec_rs1 == rd_q)) | (use_rs2 & (dec_rs2 == rd_q)));

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap_block  = illegal_q;
  assign trap_reject = dec_illegal;
  assign illegal_o   = illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      illegal_q <= 1'b0;
    end else if (handshake && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign trap_block  = 1'b0;
  assign trap_reject = 1'b0;
  assign illegal_o   = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. A stall leaves on the adv cycle that loads the last owed
  // bubble, so exactly LU_STALL bubbles reach execute per hazard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (adv) begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            cnt_d   = STALL_INIT;
            state_d = (STALL_INIT != 2'd0) ? STALL : RUN;
          end
        end
        STALL: begin
          cnt_d = (cnt_q != 2'd0) ? 2'(cnt_q - 2'd1) : 2'd0;
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM: outputs. Flush always accepts (and drops) the offered instruction.
  always_comb begin
    in_ready_o = 1'b0;
    if (!rst_i) begin
      if (flush_i) begin
        in_ready_o = 1'b1;
      end else begin
        in_ready_o = adv && (state_q == RUN) && !hazard && !trap_block;
      end
    end
  end

  assign handshake  = in_valid_i & in_ready_o;
  assign take_instr = handshake & ~trap_reject;

  // ID/EX register: anything other than an accepted legal instruction loads an all-zero bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (adv) begin
      if (take_instr) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= dec_ctrl;
        rd_q        <= dec_rd;
        rs1_q       <= dec_rs1;
        rs2_q       <= dec_rs2;
      end else begin
        out_valid_q <= 1'b0;
        ctrl_q      <= '0;
        rd_q        <= '0;
        rs1_q       <= '0;
        rs2_q       <= '0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign branch_o    = ctrl_q.branch;
  assign alusrc_o    = ctrl_q.alusrc;
  assign regwrite_o  = ctrl_q.regwrite;
  assign memread_o   = ctrl_q.memread;
  assign memwrite_o  = ctrl_q.memwrite;
  assign jump_o      = ctrl_q.jump;
  assign aluop_o     = ctrl_q.aluop;
  assign writeback_o = ctrl_q.writeback;
  assign rd_o        = rd_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;

endmodule
